// File: rtl/div_pkg.sv
// Shared types and constants for the UART byte-serial divide controller.
// Holds the controller state encoding, default status bytes and byte-count helper.
package div_pkg;

  typedef enum logic [1:0] {
    S_RX  = 2'd0,
    S_DIV = 2'd1,
    S_TX  = 2'd2
  } div_state_t;

  localparam logic [7:0] DEF_ST_OK = 8'h00;
  localparam logic [7:0] DEF_ST_DZ = 8'hEE;

  // Bytes per operand for a given operand width.
  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_div_ctrl_if.sv
// Byte-level handshake between uart_rx/uart_tx and the divide controller.
// The controller takes the slave view; the UART side (or a bench) takes the master view.
interface uart_div_ctrl_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       div_zero;

  modport master (
    output rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data, busy, div_zero
  );

  modport slave (
    input  rx_valid, rx_data, tx_busy,
    output tx_start, tx_data, busy, div_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// The first iteration happens on the start cycle itself, so a divide takes exactly W cycles.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz
);

  localparam int CW = $clog2(W);

  logic [W:0]    rem_q;
  logic [W-1:0]  quo_q;
  logic [CW-1:0] cnt_q;
  logic          running_q;
  logic          dz_q;

  logic [W:0]    rem_src;
  logic [W-1:0]  quo_src;
  logic [W+1:0]  trial;
  logic [W:0]    rem_nxt;
  logic [W-1:0]  quo_nxt;
  logic          div_by_zero;

  // One restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
  always_comb begin
    rem_src = running_q ? rem_q : '0;
    quo_src = running_q ? quo_q : dividend;
    trial   = {rem_src, quo_src[W-1]};
    rem_nxt = trial[W:0];
    quo_nxt = {quo_src[W-2:0], 1'b0};
    if (trial >= {2'b00, divisor}) begin
      rem_nxt = (W+1)'(trial - {2'b00, divisor});
      quo_nxt = {quo_src[W-2:0], 1'b1};
    end
  end

  assign div_by_zero = (divisor == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (start) begin
      if (div_by_zero) begin
        quo_q     <= '1;
        rem_q     <= {1'b0, dividend};
        dz_q      <= 1'b1;
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        quo_q     <= quo_nxt;
        rem_q     <= rem_nxt;
        dz_q      <= 1'b0;
        running_q <= 1'b1;
        cnt_q     <= CW'(1);
      end
    end else if (running_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) begin
        running_q <= 1'b0;
      end
    end
  end

  // done is combinational so the caller can leave its divide state on the final iteration edge.
  assign done      = (start && div_by_zero) || (running_q && (cnt_q == CW'(W-1)));
  assign quotient  = quo_q;
  assign remainder = rem_q[W-1:0];
  assign dz        = dz_q;

endmodule

// File: rtl/uart_div_ctrl.sv
// Byte-serial divide controller: collects dividend and divisor from uart_rx, divides,
// then returns status, quotient and remainder bytes to uart_tx with a busy-aware handshake.
module uart_div_ctrl
  import div_pkg::*;
#(
  parameter int         DATA_W       = 16,
  parameter int         BYTE_TIMEOUT = 520800,
  parameter logic [7:0] ST_OK        = DEF_ST_OK,
  parameter logic [7:0] ST_DZ        = DEF_ST_DZ
) (
  input logic            clk,
  input logic            rst,
  uart_div_ctrl_if.slave bus
);

  localparam int NB    = nb_of(DATA_W);
  localparam int BC_W  = $clog2(2*NB + 1);
  localparam int TO_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam int IDX_W = $clog2(2*NB + 2);

  div_state_t state_q, state_d;

  logic [2*DATA_W-1:0] opnd_q;
  logic [BC_W-1:0]     byte_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                div_go_q;
  logic [IDX_W-1:0]    tx_idx_q;
  logic                guard_q;
  logic [2*DATA_W-1:0] tx_buf_q;
  logic                busy_q;
  logic                div_zero_q;
  logic                tx_start_q;
  logic [7:0]          tx_data_q;

  logic rx_accept;
  logic frame_full;
  logic time_out;
  logic enter_tx;
  logic issue;
  logic tx_finish;

  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              div_done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_dz;
  logic [7:0]        status;

  assign dividend = opnd_q[2*DATA_W-1:DATA_W];
  assign divisor  = opnd_q[DATA_W-1:0];
  assign status   = div_dz ? ST_DZ : ST_OK;

  seq_divider #(.W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_go_q),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (div_dz)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RX;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus one-cycle strobes consumed by the datapath below.
  always_comb begin
    state_d    = state_q;
    rx_accept  = 1'b0;
    frame_full = 1'b0;
    time_out   = 1'b0;
    enter_tx   = 1'b0;
    issue      = 1'b0;
    tx_finish  = 1'b0;
    case (state_q)
      S_RX: begin
        rx_accept = bus.rx_valid;
        if (bus.rx_valid && (byte_cnt_q == BC_W'(2*NB - 1))) begin
          frame_full = 1'b1;
          state_d    = S_DIV;
        end
        if (!bus.rx_valid && (byte_cnt_q != '0) && (to_cnt_q == TO_W'(BYTE_TIMEOUT - 1))) begin
          time_out = 1'b1;
        end
      end
      S_DIV: begin
        if (div_done) begin
          enter_tx = 1'b1;
          state_d  = S_TX;
        end
      end
      S_TX: begin
        if (guard_q) begin
          if (tx_idx_q == IDX_W'(2*NB + 1)) begin
            tx_finish = 1'b1;
            state_d   = S_RX;
          end
        end else if (!bus.tx_busy) begin
          issue = 1'b1;
        end
      end
      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opnd_q     <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      div_go_q   <= 1'b0;
      tx_idx_q   <= '0;
      guard_q    <= 1'b0;
      tx_buf_q   <= '0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      div_go_q   <= frame_full;

      if (rx_accept) begin
        opnd_q     <= {opnd_q[2*DATA_W-9:0], bus.rx_data};
        to_cnt_q   <= '0;
        byte_cnt_q <= frame_full ? '0 : byte_cnt_q + 1'b1;
        busy_q     <= 1'b1;
        if (byte_cnt_q == '0) begin
          div_zero_q <= 1'b0;
        end
      end else if (time_out) begin
        byte_cnt_q <= '0;
        to_cnt_q   <= '0;
        busy_q     <= 1'b0;
      end else if ((state_q == S_RX) && (byte_cnt_q != '0)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (enter_tx) begin
        div_zero_q <= (divisor == '0);
        tx_idx_q   <= '0;
        guard_q    <= 1'b0;
      end

      // Status goes out first; quotient and remainder are then shifted out MSB byte first.
      if (issue) begin
        tx_start_q <= 1'b1;
        guard_q    <= 1'b1;
        tx_idx_q   <= tx_idx_q + 1'b1;
        if (tx_idx_q == '0) begin
          tx_data_q <= status;
          tx_buf_q  <= {quotient, remainder};
        end else begin
          tx_data_q <= tx_buf_q[2*DATA_W-1 -: 8];
          tx_buf_q  <= tx_buf_q << 8;
        end
      end else if (guard_q) begin
        guard_q <= 1'b0;
      end

      if (tx_finish) begin
        busy_q   <= 1'b0;
        tx_idx_q <= '0;
      end
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_uart_div_ctrl.sv
// Directed bench for uart_div_ctrl: 16-bit and 32-bit instances fed byte frames,
// transmitted bytes captured into queues and compared with hand-computed frames.
module tb_uart_div_ctrl;

  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_div_ctrl_if bus16();
  uart_div_ctrl_if bus32();

  uart_div_ctrl #(.DATA_W(16), .BYTE_TIMEOUT(TO)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  uart_div_ctrl #(.DATA_W(32), .BYTE_TIMEOUT(TO)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q16[$];
  logic [7:0] q32[$];
  int         tc16[$];
  int         tc32[$];
  int         last_rx16 = 0;
  int         last_rx32 = 0;

  // Capture every transmitted byte and the cycle it was offered, plus the cycle of the latest rx byte.
  always @(negedge clk) begin
    if (bus16.tx_start) begin
      q16.push_back(bus16.tx_data);
      tc16.push_back(cyc);
    end
    if (bus32.tx_start) begin
      q32.push_back(bus32.tx_data);
      tc32.push_back(cyc);
    end
    if (bus16.rx_valid) last_rx16 = cyc;
    if (bus32.rx_valid) last_rx32 = cyc;
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int first_tx     = 0;
  int min_gap      = 0;

  task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Sends n bytes on consecutive cycles; returns 1ns after the edge that sampled the last byte.
  task automatic applyStimulus(input int which, input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (which == 32) begin
        bus32.rx_valid = 1'b1;
        bus32.rx_data  = bytes[(n-1-i)*8 +: 8];
      end else begin
        bus16.rx_valid = 1'b1;
        bus16.rx_data  = bytes[(n-1-i)*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
    bus16.rx_valid = 1'b0;
    bus32.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int which);
    return (which == 32) ? q32.size() : q16.size();
  endfunction

  // Waits (bounded) for an n-byte response, then checks count, every byte, first cycle and spacing.
  task automatic checkFrame(input string tag, input int which, input int n, input logic [71:0] exp);
    int waited;
    int sz;
    logic [8:0] got;
    waited = 0;
    sz = qsize(which);
    while (sz < n && waited < 400) begin
      @(negedge clk);
      waited++;
      sz = qsize(which);
    end
    repeat (6) @(negedge clk);
    sz = qsize(which);
    checkOutput({tag, "_count"}, 72'(sz), 72'(n));
    for (int i = 0; i < n; i++) begin
      got = 9'h100;
      if (i < sz) got = (which == 32) ? {1'b0, q32[i]} : {1'b0, q16[i]};
      checkOutput($sformatf("%s_byte%0d", tag, i), 72'(got), 72'({1'b0, exp[(n-1-i)*8 +: 8]}));
    end
    first_tx = -1000;
    min_gap  = 1000;
    for (int i = 0; i < sz; i++) begin
      int t;
      t = (which == 32) ? tc32[i] : tc16[i];
      if (i == 0) first_tx = t;
      else if (t - ((which == 32) ? tc32[i-1] : tc16[i-1]) < min_gap)
        min_gap = t - ((which == 32) ? tc32[i-1] : tc16[i-1]);
    end
    q16.delete();
    q32.delete();
    tc16.delete();
    tc32.delete();
  endtask

  initial begin
    bus16.rx_valid = 1'b0;
    bus16.rx_data  = 8'h00;
    bus16.tx_busy  = 1'b0;
    bus32.rx_valid = 1'b0;
    bus32.rx_data  = 8'h00;
    bus32.tx_busy  = 1'b0;

    idle(3);
    checkOutput("reset_outputs", 72'({bus16.busy, bus16.div_zero, bus16.tx_start, bus16.tx_data}), 72'(0));
    rst = 1'b1;
    idle(2);

    // 1000 / 7 = 142 r 6
    applyStimulus(16, 4, 64'h03E80007);
    checkOutput("busy_during_div", 72'(bus16.busy), 72'(1));
    checkFrame("div1000_7", 16, 5, 72'h00008E0006);
    checkOutput("latency16", 72'(first_tx - last_rx16), 72'(18));
    checkOutput("div1000_7_dz", 72'(bus16.div_zero), 72'(0));
    checkOutput("busy_after_frame", 72'(bus16.busy), 72'(0));

    // Divide by zero, then the next frame's first byte clears the flag.
    applyStimulus(16, 4, 64'h12340000);
    checkFrame("divzero", 16, 5, 72'hEEFFFF1234);
    checkOutput("dz_flag_set", 72'(bus16.div_zero), 72'(1));
    applyStimulus(16, 1, 64'h12);
    checkOutput("dz_flag_cleared", 72'(bus16.div_zero), 72'(0));

    // Partial frame 12 34 is abandoned after the inter-byte timeout.
    applyStimulus(16, 1, 64'h34);
    idle(TO - 2);
    checkOutput("timeout_busy_hold", 72'(bus16.busy), 72'(1));
    idle(3);
    checkOutput("timeout_busy_drop", 72'(bus16.busy), 72'(0));
    applyStimulus(16, 4, 64'h0064000A);
    checkFrame("after_timeout", 16, 5, 72'h00000A0000);

    // Backpressure with stray rx bytes while transmitting: 42 / 5 = 8 r 2.
    bus16.tx_busy = 1'b1;
    applyStimulus(16, 4, 64'h002A0005);
    idle(30);
    applyStimulus(16, 2, 64'hAAAA);
    idle(170);
    checkOutput("bp_no_tx_while_busy", 72'(q16.size()), 72'(0));
    checkOutput("bp_busy_held", 72'(bus16.busy), 72'(1));
    bus16.tx_busy = 1'b0;
    checkFrame("backpressure", 16, 5, 72'h0000080002);
    checkOutput("bp_guard_gap", 72'(min_gap >= 2), 72'(1));
    // 200 / 12 = 16 r 8, proves the stray bytes left no residue.
    applyStimulus(16, 4, 64'h00C8000C);
    checkFrame("after_bp", 16, 5, 72'h0000100008);

    // Reset in the middle of a divide.
    applyStimulus(16, 4, 64'h03E80007);
    idle(4);
    rst = 1'b0;
    idle(1);
    checkOutput("midreset_outputs", 72'({bus16.busy, bus16.div_zero, bus16.tx_start, bus16.tx_data}), 72'(0));
    idle(1);
    rst = 1'b1;
    idle(40);
    checkOutput("midreset_no_tx", 72'(q16.size()), 72'(0));
    applyStimulus(16, 4, 64'h00050009);
    checkFrame("q0_r5", 16, 5, 72'h0000000005);

    // 32-bit instance: 0xFFFFFFFF / 16.
    applyStimulus(32, 8, 64'hFFFFFFFF00000010);
    checkFrame("w32", 32, 9, 72'h000FFFFFFF0000000F);
    checkOutput("latency32", 72'(first_tx - last_rx32), 72'(34));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_div_ctrl.md
Name: uart_div_ctrl

Overview:
Parametrised byte-serial divide controller between the uart_rx and uart_tx blocks. It collects a DATA_W-bit dividend and a DATA_W-bit divisor from received bytes, MSB first. It runs a one-bit-per-cycle restoring divide, then returns a status byte followed by the quotient and remainder through a busy-aware transmit handshake. It processes frames back to back, discards stale partial frames after an inter-byte timeout, and flags divide-by-zero.

Parameters:
DATA_W, 16, operand width in bits; must be a multiple of 8, range 8..64; NB = DATA_W/8 bytes per operand
BYTE_TIMEOUT, 520800, idle clocks inside a partial frame before it is discarded (10 byte-times at 9600 baud, 50 MHz)
ST_OK, 8'h00, status byte for a valid result
ST_DZ, 8'hEE, status byte for divide-by-zero

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
rx_valid  in  1  one-cycle pulse per received byte from uart_rx
rx_data  in  8  received byte; valid only while rx_valid=1
tx_busy  in  1  uart_tx is shifting a byte
tx_start  out  1  one-cycle pulse requesting uart_tx to send tx_data
tx_data  out  8  byte to send; stable from tx_start until the next tx_start
busy  out  1  high from the first accepted byte until the last tx_start of the frame
div_zero  out  1  set for the current frame if divisor==0; cleared when the next frame's first byte is accepted

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; state S_RX; byte count 0; timeout counter 0. This applies in any state, including mid-divide or mid-transmit. Any partially sent frame is abandoned.
- S_RX:
  - Each rx_valid stores rx_data into the operand shift registers. Bytes 0..NB-1 form the dividend, MSB first; bytes NB..2NB-1 form the divisor, MSB first.
  - On the 2NB-th byte, go to S_DIV on the next cycle.
  - busy rises the cycle after the first byte is accepted.
- Timeout:
  - In S_RX with byte count>0, a counter increments on every cycle without rx_valid.
  - When it reaches BYTE_TIMEOUT-1, byte count and counter clear and busy drops. State stays S_RX.
  - Every rx_valid clears the counter.
- rx_valid outside S_RX is ignored; the byte is dropped and nothing is queued.
- S_DIV:
  - If divisor==0: skip the divide. Quotient = all ones, remainder = dividend, status = ST_DZ, div_zero=1. Go to S_TX the next cycle.
  - Otherwise: the restoring divide takes exactly DATA_W cycles, one quotient bit per cycle, MSB first. Then status = ST_OK. Entry to S_TX follows the last iteration cycle.
  - Remainder register is DATA_W+1 bits wide internally to hold the compare/subtract. Results are unsigned, with quotient < 2^DATA_W and remainder < divisor.
- S_TX:
  - Sends 1+2NB bytes in this order: status, quotient MSB..LSB, remainder MSB..LSB.
  - A byte is issued (tx_start=1 for one cycle, tx_data updated the same cycle) only when tx_busy==0 and no guard cycle is active.
  - After each tx_start, one guard cycle ignores tx_busy to cover uart_tx's registered busy.
  - After the last tx_start, busy drops the next cycle and the state returns to S_RX with byte count 0. The next frame may start immediately.
- Latency, divisor≠0 and tx_busy idle: the first tx_start occurs DATA_W+2 cycles after the last rx_valid.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

Decomposition:
- Shared package div_pkg: state encoding (S_RX, S_DIV, S_TX), ST_OK, ST_DZ, and the NB = DATA_W/8 helper constant.
- One sub-module seq_divider, parameter W:
  - Inputs: start, dividend, divisor.
  - Outputs: done pulse, quotient, remainder, dz flag.
  - Behaviour: DATA_W-cycle restoring divide, synchronous active-low reset.
- Top level holds the rx assembly, timeout counter and tx sequencer.

Test Plan:
- DATA_W=16; rx 03 E8 00 07 (1000/7) -> tx 00 00 8E 00 06, div_zero=0, first tx_start 18 cycles after the last rx_valid.
- Divide-by-zero: rx 12 34 00 00 -> tx EE FF FF 12 34, div_zero=1; it clears on the next frame's first byte.
- Timeout: rx 12 34, idle BYTE_TIMEOUT cycles, then rx 00 64 00 0A -> tx 00 00 0A 00 00; no trace of the 12 34 bytes.
- Backpressure: hold tx_busy=1 for 200 cycles after S_TX entry -> no tx_start while tx_busy=1. Then exactly 5 tx_starts, each separated by at least the guard cycle plus tx_busy low. Extra rx_valid during S_TX is ignored.
- Reset mid-divide: assert rst at divide cycle 5 -> outputs 0 next cycle, no tx_start; a following frame 00 05 00 09 -> tx 00 00 00 00 05 (q=0, r=5).
- DATA_W=32: rx FF FF FF FF 00 00 00 10 -> tx 00 0F FF FF FF 00 00 00 0F.
